// File: rtl/bus_if_pkg.sv
// Shared encodings and widths for the CPU bus interface: FSM states, active-low
// strobe levels, read/write polarity and the address/data field layout.
package bus_if_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int SPM_ADDR_W  = 12;

  localparam int SLV_IDX_MSB = 29;
  localparam int SLV_IDX_LSB = 27;
  localparam int SLV_IDX_W   = SLV_IDX_MSB - SLV_IDX_LSB + 1;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_t;

endpackage

// File: rtl/bus_if_if.sv
// Shared-bus signal bundle between the CPU bus interface (master) and the bus
// arbiter/slaves (slave). All strobes are active-low.
interface bus_if_if;
  import bus_if_pkg::*;

  logic                   bus_req_;
  logic                   bus_grnt_;
  logic [WORD_ADDR_W-1:0] bus_addr;
  logic                   bus_as_;
  logic                   bus_rw;
  logic [WORD_DATA_W-1:0] bus_wr_data;
  logic [WORD_DATA_W-1:0] bus_rd_data;
  logic                   bus_rdy_;

  modport master (
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );

endinterface

// File: rtl/bus_if.sv
// CPU-side bus interface: routes accesses either to the local scratchpad
// (zero-wait, combinational) or to the shared bus through a request/grant FSM.
module bus_if
  import bus_if_pkg::*;
#(
  parameter logic [SLV_IDX_W-1:0] SPM_IDX = 3'b001
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   busy,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic [WORD_DATA_W-1:0] rd_data,
  input  logic [WORD_DATA_W-1:0] spm_rd_data,
  output logic [SPM_ADDR_W-1:0]  spm_addr,
  output logic                   spm_as_,
  output logic                   spm_rw,
  output logic [WORD_DATA_W-1:0] spm_wr_data,
  bus_if_if.master               bus
);

  state_t                 state;
  state_t                 next_state;
  logic [WORD_DATA_W-1:0] rd_buf;
  logic                   access;
  logic                   spm_hit;
  logic                   bus_done;

  assign access   = (state == IDLE) && !flush && (as_ == ENABLE_);
  assign spm_hit  = access && (addr[SLV_IDX_MSB:SLV_IDX_LSB] == SPM_IDX);
  assign bus_done = (state == ACCESS) && (bus.bus_rdy_ == ENABLE_);

  assign spm_addr    = addr[SPM_ADDR_W-1:0];
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    rd_data    = '0;
    spm_as_    = DISABLE_;
    case (state)
      IDLE: begin
        if (spm_hit) begin
          spm_as_ = ENABLE_;
          rd_data = spm_rd_data;
        end else if (access) begin
          busy       = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (bus.bus_grnt_ == ENABLE_) next_state = ACCESS;
      end
      ACCESS: begin
        if (bus_done) begin
          rd_data    = bus.bus_rd_data;
          next_state = stall ? STALL : IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      STALL: begin
        rd_data = rd_buf;
        // A flush discards the held result even while the pipeline is stalled.
        if (!stall || flush) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      bus.bus_req_    <= DISABLE_;
      bus.bus_as_     <= DISABLE_;
      bus.bus_rw      <= READ;
      bus.bus_addr    <= '0;
      bus.bus_wr_data <= '0;
      rd_buf          <= '0;
    end else begin
      // Strobe is only ever a single-cycle pulse on the REQ->ACCESS edge.
      bus.bus_as_ <= ((state == REQ) && (bus.bus_grnt_ == ENABLE_)) ? ENABLE_ : DISABLE_;
      if (access && !spm_hit) begin
        bus.bus_req_    <= ENABLE_;
        bus.bus_addr    <= addr;
        bus.bus_rw      <= rw;
        bus.bus_wr_data <= wr_data;
      end
      if (bus_done) begin
        bus.bus_req_ <= DISABLE_;
        if (bus.bus_rw == READ) rd_buf <= bus.bus_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_bus_if.sv
// Directed scoreboard bench for bus_if: stimulus pushes expected read data,
// a negedge monitor pops and compares whenever a response is presented.
module tb_bus_if;
  import bus_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset_;
  logic        stall;
  logic        flush;
  logic        busy;
  logic [29:0] addr;
  logic        as_;
  logic        rw;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [31:0] spm_rd_data;
  logic [11:0] spm_addr;
  logic        spm_as_;
  logic        spm_rw;
  logic [31:0] spm_wr_data;

  bus_if_if bus ();

  bus_if #(.SPM_IDX(3'b001)) dut (
    .clk(clk), .reset_(reset_), .stall(stall), .flush(flush), .busy(busy),
    .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
    .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_),
    .spm_rw(spm_rw), .spm_wr_data(spm_wr_data), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_read = 32'h0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // A response is presented on an SPM hit or on the bus ready cycle.
  always @(negedge clk) begin
    if (reset_ && (!spm_as_ || (!bus.bus_req_ && !bus.bus_rdy_))) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_response actual=%h expected=none", rd_data);
      end else begin
        check_output("sb_rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic apply_stimulus(input logic [29:0] a, input logic rwv, input logic [31:0] wd,
                                input logic [31:0] rd, input int gnt_wait, input int rdy_wait,
                                input logic st, input logic fl_acc, input logic fl_stall);
    addr = a; as_ = 1'b0; rw = rwv; wr_data = wd;
    @(negedge clk);
    check_output("idle_busy", 32'(busy), 32'd1);
    check_output("idle_req_high", 32'(bus.bus_req_), 32'd1);
    @(posedge clk) #1;
    @(negedge clk);
    check_output("req_low", 32'(bus.bus_req_), 32'd0);
    check_output("bus_addr", 32'(bus.bus_addr), 32'(a));
    check_output("bus_rw", 32'(bus.bus_rw), 32'(rwv));
    check_output("bus_wr_data", bus.bus_wr_data, wd);
    check_output("req_busy", 32'(busy), 32'd1);
    for (int i = 0; i < gnt_wait; i++) @(posedge clk) #1;
    bus.bus_grnt_ = 1'b0;
    @(posedge clk) #1;
    bus.bus_grnt_ = 1'b1;
    flush = fl_acc;
    @(negedge clk);
    check_output("as_low", 32'(bus.bus_as_), 32'd0);
    check_output("access_busy", 32'(busy), 32'd1);
    for (int i = 0; i < rdy_wait; i++) begin
      @(posedge clk) #1;
      @(negedge clk);
      check_output("as_high", 32'(bus.bus_as_), 32'd1);
      check_output("wait_busy", 32'(busy), 32'd1);
    end
    @(posedge clk) #1;
    bus.bus_rdy_ = 1'b0; bus.bus_rd_data = rd; stall = st;
    exp_q.push_back(rd);
    @(negedge clk);
    check_output("ready_busy", 32'(busy), 32'd0);
    @(posedge clk) #1;
    bus.bus_rdy_ = 1'b1; as_ = 1'b1; flush = 1'b0;
    if (rwv == READ) last_read = rd;
    @(negedge clk);
    check_output("req_released", 32'(bus.bus_req_), 32'd1);
    if (st) begin
      check_output("state_stall", 32'(dut.state), 32'(STALL));
      check_output("stall_busy", 32'(busy), 32'd0);
      check_output("stall_rd_buf", rd_data, last_read);
      if (fl_stall) begin
        flush = 1'b1;
        @(posedge clk) #1;
        flush = 1'b0;
      end else begin
        @(posedge clk) #1;
        @(negedge clk);
        check_output("stall_hold", 32'(dut.state), 32'(STALL));
        stall = 1'b0;
        @(posedge clk) #1;
      end
      @(negedge clk);
      check_output("stall_exit_idle", 32'(dut.state), 32'(IDLE));
      stall = 1'b0;
    end else begin
      check_output("done_idle", 32'(dut.state), 32'(IDLE));
    end
    check_output("idle_rd_zero", rd_data, 32'h0);
    @(posedge clk) #1;
  endtask

  initial begin
    reset_ = 1'b0; stall = 1'b0; flush = 1'b0; addr = '0; as_ = 1'b1; rw = READ;
    wr_data = '0; spm_rd_data = '0;
    bus.bus_grnt_ = 1'b1; bus.bus_rdy_ = 1'b1; bus.bus_rd_data = '0;
    @(negedge clk);
    check_output("rst_req", 32'(bus.bus_req_), 32'd1);
    check_output("rst_as", 32'(bus.bus_as_), 32'd1);
    check_output("rst_rw", 32'(bus.bus_rw), 32'd1);
    check_output("rst_addr", 32'(bus.bus_addr), 32'd0);
    check_output("rst_wdata", bus.bus_wr_data, 32'h0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_rd_data", rd_data, 32'h0);
    @(posedge clk) #1;
    reset_ = 1'b1;
    @(posedge clk) #1;

    // SPM read
    addr = 30'h0800_0010; as_ = 1'b0; rw = READ; spm_rd_data = 32'hCAFE_0001;
    exp_q.push_back(32'hCAFE_0001);
    @(negedge clk);
    check_output("spm_as", 32'(spm_as_), 32'd0);
    check_output("spm_addr", 32'(spm_addr), 32'h010);
    check_output("spm_rw", 32'(spm_rw), 32'd1);
    check_output("spm_busy", 32'(busy), 32'd0);
    check_output("spm_no_req", 32'(bus.bus_req_), 32'd1);
    @(posedge clk) #1;
    as_ = 1'b1;
    @(negedge clk);
    check_output("spm_state", 32'(dut.state), 32'(IDLE));
    check_output("spm_after_req", 32'(bus.bus_req_), 32'd1);
    @(posedge clk) #1;

    // Bus read, write held in stall, flush during access, flush during stall
    apply_stimulus(30'h1000_0004, READ,  32'h0000_0000, 32'h1234_5678, 2, 2, 1'b0, 1'b0, 1'b0);
    apply_stimulus(30'h1000_0020, WRITE, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 0, 1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(30'h1800_0008, READ,  32'h0000_0000, 32'h5555_AAAA, 1, 1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(30'h2000_0100, READ,  32'h0000_0000, 32'h0F0F_1111, 0, 0, 1'b1, 1'b0, 1'b1);

    // Flush in IDLE suppresses both SPM and bus accesses
    flush = 1'b1; as_ = 1'b0; addr = 30'h0800_0010;
    @(negedge clk);
    check_output("flush_spm_as", 32'(spm_as_), 32'd1);
    check_output("flush_spm_busy", 32'(busy), 32'd0);
    addr = 30'h1000_0004;
    @(posedge clk) #1;
    @(negedge clk);
    check_output("flush_bus_busy", 32'(busy), 32'd0);
    check_output("flush_no_req", 32'(bus.bus_req_), 32'd1);
    flush = 1'b0; as_ = 1'b1;
    @(posedge clk) #1;

    // Reset asserted while the strobe is out
    addr = 30'h1000_0040; as_ = 1'b0; rw = READ;
    @(posedge clk) #1;
    as_ = 1'b1; bus.bus_grnt_ = 1'b0;
    @(posedge clk) #1;
    bus.bus_grnt_ = 1'b1;
    check_output("pre_rst_as", 32'(bus.bus_as_), 32'd0);
    #2 reset_ = 1'b0;
    #1;
    check_output("mid_rst_req", 32'(bus.bus_req_), 32'd1);
    check_output("mid_rst_as", 32'(bus.bus_as_), 32'd1);
    check_output("mid_rst_state", 32'(dut.state), 32'(IDLE));
    check_output("mid_rst_addr", 32'(bus.bus_addr), 32'd0);
    @(posedge clk) #1;
    reset_ = 1'b1;
    @(posedge clk) #1;
    @(negedge clk);
    check_output("post_rst_idle", 32'(dut.state), 32'(IDLE));
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_if.md
BUS_IF -- requirements
Module: bus_if

Interface
REQ-001 Parameter SPM_IDX, default 3'b001, SHALL give the addr[29:27] value that selects the scratchpad; every other value selects the shared bus.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset_  in  1  asynchronous, active-low reset.
REQ-004 stall  in  1  pipeline stall; holds the completed bus result.
REQ-005 flush  in  1  pipeline flush; suppresses new accesses.
REQ-006 busy  out  1  bus access in progress; the pipeline must stall.
REQ-007 addr  in  30  CPU word address.
REQ-008 as_  in  1  CPU address strobe, active-low.
REQ-009 rw  in  1  CPU read (1) / write (0).
REQ-010 wr_data  in  32  CPU write data.
REQ-011 rd_data  out  32  read data returned to the CPU.
REQ-012 spm_rd_data  in  32  scratchpad read data.
REQ-013 spm_addr  out  12  scratchpad word address, equal to addr[11:0].
REQ-014 spm_as_  out  1  scratchpad strobe, active-low.
REQ-015 spm_rw  out  1  scratchpad read/write, equal to rw.
REQ-016 spm_wr_data  out  32  scratchpad write data, equal to wr_data.
REQ-017 bus_rd_data  in  32  bus read data.
REQ-018 bus_rdy_  in  1  bus ready, active-low.
REQ-019 bus_grnt_  in  1  bus grant, active-low.
REQ-020 bus_req_  out  1  bus request, active-low, registered.
REQ-021 bus_addr  out  30  bus address, registered.
REQ-022 bus_as_  out  1  bus strobe, active-low, registered.
REQ-023 bus_rw  out  1  bus read/write, registered.
REQ-024 bus_wr_data  out  32  bus write data, registered.

Function
REQ-025 The FSM SHALL have exactly four states: IDLE, REQ, ACCESS, STALL.
REQ-026 In IDLE with flush=0 and as_=0, an access is an SPM hit when addr[29:27]=SPM_IDX.
REQ-027 On an SPM hit, the block SHALL drive spm_as_=0 combinationally, drive rd_data=spm_rd_data, hold busy=0 and stay in IDLE.
REQ-028 In IDLE, a non-SPM access SHALL set busy=1 combinationally; at the next edge it SHALL set bus_req_=0, latch addr, rw and wr_data into bus_addr, bus_rw and bus_wr_data, and enter REQ.
REQ-029 In REQ, busy SHALL be 1; when bus_grnt_=0 the next edge SHALL set bus_as_=0 and enter ACCESS.
REQ-030 The cycle after entering ACCESS, bus_as_ SHALL return to 1, so the strobe is exactly one cycle wide.
REQ-031 In ACCESS with bus_rdy_=1, the block SHALL hold busy=1 and stay in ACCESS.
REQ-032 When bus_rdy_=0 in ACCESS:
- busy SHALL be 0 that cycle and rd_data SHALL equal bus_rd_data;
- at the edge, bus_req_ SHALL go to 1, rd_buf SHALL capture bus_rd_data (reads only), and the next state SHALL be STALL if stall=1, else IDLE.
REQ-033 In STALL, rd_data SHALL equal rd_buf and busy SHALL be 0; the block SHALL return to IDLE at the first edge with stall=0.
REQ-034 In IDLE with no bus result pending and no SPM hit, rd_data SHALL be 32'h0.
REQ-035 A flush during REQ or ACCESS SHALL NOT abort the bus transaction; a flush during STALL SHALL force IDLE at the next edge.
REQ-036 spm_as_ SHALL be 1 whenever the state is not IDLE, or flush=1, or the access is not an SPM hit.
REQ-037 The block SHALL never assert bus_req_=0 and spm_as_=0 in the same cycle.

Reset
REQ-038 While reset_=0, asynchronously: state=IDLE, bus_req_=1, bus_as_=1, bus_rw=1 (read), bus_addr=0, bus_wr_data=0, rd_buf=0.
REQ-039 A reset asserted mid-transaction SHALL release the bus immediately (bus_req_=1, bus_as_=1), with no completion.

Structure
REQ-040 The shared package SHALL hold: state encodings, ENABLE_/DISABLE_, READ/WRITE, the word-address, word-data and SPM-address widths, and the slave-index field position [29:27].
REQ-041 The block SHALL be flat, with no sub-module; the SPM instance stays external.

Verification
REQ-042 SPM read: addr=30'h0800_0010, as_=0, rw=1, spm_rd_data=32'hCAFE_0001 -> spm_as_=0, spm_addr=12'h010, rd_data=32'hCAFE_0001, busy=0, bus_req_=1.
REQ-043 Bus read: addr=30'h1000_0004, grant after 2 cycles, bus_rdy_=0 after 3 cycles with bus_rd_data=32'h1234_5678 -> busy=1 until the ready cycle, bus_as_ low for one cycle, rd_data=32'h1234_5678.
REQ-044 Bus write held in stall: rw=0, wr_data=32'hA5A5_A5A5, stall=1 at ready -> bus_wr_data=32'hA5A5_A5A5, FSM in STALL, busy=0 until stall=0, then IDLE.
REQ-045 Flush: flush=1 with as_=0 in IDLE -> no spm_as_, no bus_req_; flush during ACCESS -> transaction still completes on bus_rdy_.
REQ-046 Reset in ACCESS: reset_=0 -> bus_req_=1, bus_as_=1 in the same cycle, state=IDLE.
